// File: rtl/color_config_sequencer.sv
// -----------------------------------------------------------------------------
// color_config_sequencer
//
// Boot/preset configuration controller for color_processor_wrapper. A rising
// edge on start while idle launches a sequence that selects each of the four
// pixel channels in turn and writes colour registers 3..8 of that channel over
// a 4-phase valid/ack handshake. The written data comes from one of four preset
// tables, chosen by preset_sel when the sequence is launched.
//
// Ports
//   clk         in   1  system clock
//   rst         in   1  asynchronous reset, active-high
//   start       in   1  level; a rising edge while idle launches a sequence
//   preset_sel  in   2  preset table select, sampled on the launching edge
//   channel     out  2  channel select to the wrapper
//   address     out  4  register address to the wrapper
//   data        out  4  register data to the wrapper
//   valid       out  1  write request to the wrapper
//   ack         in   1  write acknowledge from the wrapper
//   busy        out  1  high from launch until the DONE/ABORT state
//   done        out  1  one-cycle pulse on successful completion
//   error       out  1  sticky abort flag, cleared by the next launch
//
// Every output is a flop, so address/channel/data cannot glitch while valid is
// high and a reset drops valid immediately.
// -----------------------------------------------------------------------------
module color_config_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 8,   // quiet cycles after a channel change
    parameter int unsigned ACK_TIMEOUT   = 64,  // cycles valid may wait for ack
    parameter int unsigned MAX_RETRY     = 2    // re-attempts after a timeout
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] preset_sel,
    output logic [1:0] channel,
    output logic [3:0] address,
    output logic [3:0] data,
    output logic       valid,
    input  logic       ack,
    output logic       busy,
    output logic       done,
    output logic       error
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam int unsigned CNT_MAX = (SETTLE_CYCLES > ACK_TIMEOUT) ? SETTLE_CYCLES : ACK_TIMEOUT;
    localparam int unsigned CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
    localparam int unsigned RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [CNT_W-1:0]   SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRY);

    localparam logic [3:0] FIRST_ADDR   = 4'd3;
    localparam logic [3:0] LAST_ADDR    = 4'd8;
    localparam logic [1:0] LAST_CHANNEL = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,     // waiting for a start edge
        S_SETTLE,   // channel held stable before its first write
        S_WRITE,    // valid high, waiting for ack or timeout
        S_GAP,      // one idle cycle between a timeout and the retry
        S_RELEASE,  // ack seen, waiting for ack to drop (4-phase)
        S_DONE,     // one-cycle completion pulse
        S_ABORT     // retries exhausted
    } state_t;

    // -------------------------------------------------------------------------
    // Preset table lookup
    // -------------------------------------------------------------------------
    function automatic logic [3:0] preset_data(input logic [1:0] sel,
                                               input logic [1:0] ch,
                                               input logic [3:0] addr);
        logic [3:0] value;
        value = 4'h0;
        case (sel)
            2'd0: begin
                case (ch)
                    2'd0:    value = 4'hA;
                    2'd1:    value = 4'h5;
                    2'd2:    value = 4'h9;
                    default: value = 4'h7;
                endcase
            end
            2'd1:    value = 4'h0;
            2'd2:    value = 4'hF;
            default: value = addr ^ {2'b00, ch};
        endcase
        return value;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t             state_q,   state_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;      // settle count or ack wait count
    logic [RETRY_W-1:0] retry_q,   retry_d;    // re-attempts used on this register
    logic [1:0]         preset_q,  preset_d;
    logic               start_q,   start_d;    // previous start level, for edge detect
    logic [1:0]         channel_q, channel_d;
    logic [3:0]         address_q, address_d;
    logic [3:0]         data_q,    data_d;
    logic               valid_q,   valid_d;
    logic               busy_q,    busy_d;
    logic               done_q,    done_d;
    logic               error_q,   error_d;

    logic               launch;
    logic [3:0]         next_address;
    logic [1:0]         next_channel;

    assign launch       = start && !start_q;
    assign next_address = address_q + 4'd1;
    assign next_channel = channel_q + 2'd1;

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned; an unassigned path in always_comb infers a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        retry_d   = retry_q;
        preset_d  = preset_q;
        start_d   = start;
        channel_d = channel_q;
        address_d = address_q;
        data_d    = data_q;
        valid_d   = valid_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        error_d   = error_q;

        case (state_q)
            S_IDLE: begin
                if (launch) begin
                    preset_d  = preset_sel;
                    error_d   = 1'b0;
                    busy_d    = 1'b1;
                    channel_d = 2'd0;
                    address_d = FIRST_ADDR;
                    data_d    = preset_data(preset_sel, 2'd0, FIRST_ADDR);
                    cnt_d     = '0;
                    state_d   = S_SETTLE;
                end
            end

            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    retry_d = '0;
                    valid_d = 1'b1;
                    state_d = S_WRITE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_WRITE: begin
                if (ack) begin
                    valid_d = 1'b0;
                    cnt_d   = '0;
                    state_d = S_RELEASE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    // valid has now been high for ACK_TIMEOUT cycles
                    valid_d = 1'b0;
                    cnt_d   = '0;
                    if (retry_q < RETRY_LIMIT) begin
                        retry_d = retry_q + 1'b1;
                        state_d = S_GAP;
                    end else begin
                        busy_d  = 1'b0;
                        error_d = 1'b1;
                        state_d = S_ABORT;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_GAP: begin
                valid_d = 1'b1;
                state_d = S_WRITE;
            end

            S_RELEASE: begin
                // Address/channel only move once ack is low, so the wrapper
                // never sees a new write while still acknowledging the old one.
                if (!ack) begin
                    retry_d = '0;
                    if (address_q < LAST_ADDR) begin
                        address_d = next_address;
                        data_d    = preset_data(preset_q, channel_q, next_address);
                        valid_d   = 1'b1;
                        state_d   = S_WRITE;
                    end else if (channel_q != LAST_CHANNEL) begin
                        channel_d = next_channel;
                        address_d = FIRST_ADDR;
                        data_d    = preset_data(preset_q, next_channel, FIRST_ADDR);
                        cnt_d     = '0;
                        state_d   = S_SETTLE;
                    end else begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_DONE;
                    end
                end
            end

            // A start edge arriving during DONE/ABORT is consumed by the edge
            // detector and does not launch.
            S_DONE:  state_d = S_IDLE;
            S_ABORT: state_d = S_IDLE;

            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            retry_q   <= '0;
            preset_q  <= 2'd0;
            start_q   <= 1'b0;
            channel_q <= 2'd0;
            address_q <= 4'd0;
            data_q    <= 4'd0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            preset_q  <= preset_d;
            start_q   <= start_d;
            channel_q <= channel_d;
            address_q <= address_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    assign channel = channel_q;
    assign address = address_q;
    assign data    = data_q;
    assign valid   = valid_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign error   = error_q;

endmodule
